duplex_mem_err_gen: RTL and testbench

- Memory-side error generator for the duplex memory pair.
- Checks the serial read streams from memory A and memory B one syllable at a time.
- Produces the per-memory parity error levels EAP/EBP and the per-module drive-sense error lines ED0X..ED7Y consumed by the error detection/switchover logic.
- Also flags A/B data miscompare and keeps saturating parity-error counts for telemetry.

---
 rtl/duplex_mem_err_gen.sv | 158 +++++++++++++++
 tb/tb_duplex_mem_err_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/duplex_mem_err_gen.sv
// ---------------------------------------------------------------------------
// duplex_mem_err_gen
//
// Memory-side error generator for a duplex memory pair. The serial read
// streams from memory A and memory B are checked one syllable at a time:
// running parity is accumulated per stream and evaluated at the parity bit
// (the last bit of the syllable). Drive-sense faults from the selected memory
// module are latched into per-module error lines, A/B data disagreement is
// flagged, and saturating parity-error counts are kept for telemetry.
//
// Parameters
//   SYLL_BITS  : bit-times per syllable (data bits + trailing parity bit)
//   PARITY_ODD : 1 = odd parity expected over the whole syllable, 0 = even
//   CNT_WIDTH  : width of each saturating error counter
//
// Ports
//   CLK, RESETN          : clock, asynchronous active-low reset
//   BIT_EN               : bit-time strobe; all state advances only when high
//   SYLL_START           : with BIT_EN, current bit is bit 0 of a new syllable
//   TIME                 : read-check window
//   SRA, SRB             : serial read data from memory A / memory B
//   MOD_SEL              : active memory module 0..7
//   DRV_ERR_X, DRV_ERR_Y : drive current sense faults of the selected module
//   SYNC                 : clears EDX, EDY and MISCMP
//   CLRCNT               : clears both error counters
//   EAP, EBP             : parity error levels for memory A / memory B
//   EDX, EDY             : per-module X / Y drive-sense error latches
//   MISCMP               : A/B miscompare latch
//   ERRCNT_A, ERRCNT_B   : saturating parity-error counts
// All outputs are registered; there are no combinational input-to-output paths.
// ---------------------------------------------------------------------------
module duplex_mem_err_gen #(
  parameter int SYLL_BITS  = 14,
  parameter int PARITY_ODD = 1,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 BIT_EN,
  input  logic                 SYLL_START,
  input  logic                 TIME,
  input  logic                 SRA,
  input  logic                 SRB,
  input  logic [2:0]           MOD_SEL,
  input  logic                 DRV_ERR_X,
  input  logic                 DRV_ERR_Y,
  input  logic                 SYNC,
  input  logic                 CLRCNT,
  output logic                 EAP,
  output logic                 EBP,
  output logic [7:0]           EDX,
  output logic [7:0]           EDY,
  output logic                 MISCMP,
  output logic [CNT_WIDTH-1:0] ERRCNT_A,
  output logic [CNT_WIDTH-1:0] ERRCNT_B
);

  localparam int            BC_W     = $clog2(SYLL_BITS);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(SYLL_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  logic [BC_W-1:0] bc;      // index of the bit expected on the next strobe
  logic            pa;      // running parity of stream A
  logic            pb;      // running parity of stream B
  logic            active;  // a syllable is in progress

  // Decoded events for the current cycle.
  logic            start_evt;
  logic            bit_evt;
  logic            eval_evt;
  logic            err_a;
  logic            err_b;
  logic            mis_evt;
  logic            ed_evt;
  logic [7:0]      mod_dec;
  logic [7:0]      set_x;
  logic [7:0]      set_y;

  assign start_evt = BIT_EN & SYLL_START;
  // A mid-syllable SYLL_START takes priority, so the parity bit is only
  // evaluated on an ordinary strobe of an active syllable.
  assign bit_evt   = BIT_EN & ~SYLL_START & active;
  assign eval_evt  = bit_evt & (bc == LAST_BIT);

  assign err_a     = eval_evt & TIME & ((pa ^ SRA) != ODD);
  assign err_b     = eval_evt & TIME & ((pb ^ SRB) != ODD);

  assign mis_evt   = BIT_EN & TIME & (active | SYLL_START) & (SRA != SRB);

  assign ed_evt    = start_evt & TIME;
  assign mod_dec   = 8'(1) << MOD_SEL;
  assign set_x     = (ed_evt & DRV_ERR_X) ? mod_dec : 8'h00;
  assign set_y     = (ed_evt & DRV_ERR_Y) ? mod_dec : 8'h00;

  // Syllable sequencing, parity accumulation and parity error levels.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      bc     <= '0;
      pa     <= 1'b0;
      pb     <= 1'b0;
      active <= 1'b0;
      EAP    <= 1'b0;
      EBP    <= 1'b0;
    end else if (start_evt) begin
      // Bit 0 of a new syllable; any partial syllable is discarded.
      bc     <= BC_W'(1);
      pa     <= SRA;
      pb     <= SRB;
      active <= 1'b1;
      EAP    <= 1'b0;
      EBP    <= 1'b0;
    end else if (eval_evt) begin
      bc     <= '0;
      active <= 1'b0;
      EAP    <= err_a;
      EBP    <= err_b;
    end else if (bit_evt) begin
      bc     <= bc + BC_W'(1);
      pa     <= pa ^ SRA;
      pb     <= pb ^ SRB;
    end
  end

  // Saturating error counters; a clear beats a same-cycle increment.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ERRCNT_A <= '0;
      ERRCNT_B <= '0;
    end else if (CLRCNT) begin
      ERRCNT_A <= '0;
      ERRCNT_B <= '0;
    end else begin
      if (err_a && (ERRCNT_A != '1)) ERRCNT_A <= ERRCNT_A + CNT_WIDTH'(1);
      if (err_b && (ERRCNT_B != '1)) ERRCNT_B <= ERRCNT_B + CNT_WIDTH'(1);
    end
  end

  // Drive-sense and miscompare latches. SYNC clears them, but an error set in
  // the same cycle still lands so no fault is lost across a resync.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      EDX    <= 8'h00;
      EDY    <= 8'h00;
      MISCMP <= 1'b0;
    end else if (SYNC) begin
      EDX    <= set_x;
      EDY    <= set_y;
      MISCMP <= mis_evt;
    end else begin
      EDX    <= EDX | set_x;
      EDY    <= EDY | set_y;
      MISCMP <= MISCMP | mis_evt;
    end
  end

endmodule

// File: tb/tb_duplex_mem_err_gen.sv
// ---------------------------------------------------------------------------
// tb_duplex_mem_err_gen
//
// Directed bench for duplex_mem_err_gen. Syllables are sent MSB first, one
// bit per clock. Expected output sets are pushed to a queue as each step is
// driven and popped and compared once the DUT has registered the result.
// ---------------------------------------------------------------------------
module tb_duplex_mem_err_gen;

  localparam logic [13:0] GOOD = 14'b10000000000000;  // one 1: odd parity
  localparam logic [13:0] BAD  = 14'b10000000000001;  // last bit flipped

  logic       clk = 1'b0;
  logic       resetn;
  logic       bit_en, syll_start, tim, sra, srb;
  logic [2:0] mod_sel;
  logic       drv_err_x, drv_err_y, sync, clrcnt;
  logic       eap, ebp, miscmp;
  logic [7:0] edx, edy;
  logic [3:0] errcnt_a, errcnt_b;

  int checks   = 0;
  int failures = 0;

  logic [3:0] m_ca = 4'd0;
  logic [3:0] m_cb = 4'd0;

  typedef struct {
    string      tag;
    logic       eap;
    logic       ebp;
    logic       mis;
    logic [7:0] edx;
    logic [7:0] edy;
    logic [3:0] ca;
    logic [3:0] cb;
  } exp_t;

  exp_t exp_q[$];

  duplex_mem_err_gen #(
    .SYLL_BITS (14),
    .PARITY_ODD(1),
    .CNT_WIDTH (4)
  ) dut (
    .CLK       (clk),
    .RESETN    (resetn),
    .BIT_EN    (bit_en),
    .SYLL_START(syll_start),
    .TIME      (tim),
    .SRA       (sra),
    .SRB       (srb),
    .MOD_SEL   (mod_sel),
    .DRV_ERR_X (drv_err_x),
    .DRV_ERR_Y (drv_err_y),
    .SYNC      (sync),
    .CLRCNT    (clrcnt),
    .EAP       (eap),
    .EBP       (ebp),
    .EDX       (edx),
    .EDY       (edy),
    .MISCMP    (miscmp),
    .ERRCNT_A  (errcnt_a),
    .ERRCNT_B  (errcnt_b)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string fld,
                     input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp_v);
    end
  endtask

  task automatic expect_out(input string tag, input logic e_eap, input logic e_ebp,
                            input logic e_mis, input logic [7:0] e_edx,
                            input logic [7:0] e_edy, input logic [3:0] e_ca,
                            input logic [3:0] e_cb);
    exp_t e;
    e.tag = tag; e.eap = e_eap; e.ebp = e_ebp; e.mis = e_mis;
    e.edx = e_edx; e.edy = e_edy; e.ca = e_ca; e.cb = e_cb;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = exp_q.pop_front();
    cmp(e.tag, "eap",    {7'd0, eap},      {7'd0, e.eap});
    cmp(e.tag, "ebp",    {7'd0, ebp},      {7'd0, e.ebp});
    cmp(e.tag, "miscmp", {7'd0, miscmp},   {7'd0, e.mis});
    cmp(e.tag, "edx",    edx,              e.edx);
    cmp(e.tag, "edy",    edy,              e.edy);
    cmp(e.tag, "cnt_a",  {4'd0, errcnt_a}, {4'd0, e.ca});
    cmp(e.tag, "cnt_b",  {4'd0, errcnt_b}, {4'd0, e.cb});
  endtask

  task automatic idle();
    bit_en = 0; syll_start = 0; tim = 0; sra = 0; srb = 0;
    mod_sel = 3'd0; drv_err_x = 0; drv_err_y = 0; sync = 0; clrcnt = 0;
  endtask

  // Apply one cycle of inputs, clock it, and settle 1 ns past the edge.
  task automatic drive_bit(input logic en, input logic a, input logic b,
                           input logic st, input logic t, input logic sy,
                           input logic cl, input logic dx, input logic dy,
                           input logic [2:0] ms);
    bit_en = en; sra = a; srb = b; syll_start = st; tim = t;
    sync = sy; clrcnt = cl; drv_err_x = dx; drv_err_y = dy; mod_sel = ms;
    @(posedge clk);
    #1;
  endtask

  task automatic send_syll(input logic [13:0] a, input logic [13:0] b,
                           input logic tim_body, input logic tim_par,
                           input logic clr_par, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(1'b1, a[13-i], b[13-i], (i == 0),
                (i == 13) ? tim_par : tim_body, 1'b0,
                (i == 13) ? clr_par : 1'b0, 1'b0, 1'b0, 3'd0);
    end
    idle();
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 8'h00, 8'h00, 0, 0);
    check_out();
    @(negedge clk);
    resetn = 1'b1;

    // Clean odd-parity syllable on both streams.
    send_syll(GOOD, GOOD, 1, 1, 0, 14);
    expect_out("clean", 0, 0, 0, 8'h00, 8'h00, 0, 0);
    check_out();

    // A parity error only; streams differ on the parity bit.
    send_syll(BAD, GOOD, 1, 1, 0, 14);
    m_ca = 4'd1;
    expect_out("a_err", 1, 0, 1, 8'h00, 8'h00, m_ca, m_cb);
    check_out();

    // Next SYLL_START clears EAP; MISCMP holds until SYNC.
    drive_bit(1, 0, 0, 1, 1, 0, 0, 0, 0, 3'd0);
    expect_out("eap_clr", 0, 0, 1, 8'h00, 8'h00, m_ca, m_cb);
    check_out();
    drive_bit(0, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0);
    expect_out("sync_mis", 0, 0, 0, 8'h00, 8'h00, m_ca, m_cb);
    check_out();

    // Error stream with TIME low at the parity bit: no evaluation.
    send_syll(BAD, GOOD, 1, 0, 0, 14);
    expect_out("time_gate", 0, 0, 0, 8'h00, 8'h00, m_ca, m_cb);
    check_out();

    // Abort after 7 bits, then a full good syllable.
    send_syll(GOOD, GOOD, 1, 1, 0, 7);
    send_syll(GOOD, GOOD, 1, 1, 0, 14);
    expect_out("resync", 0, 0, 0, 8'h00, 8'h00, m_ca, m_cb);
    check_out();

    // 17 bad-A syllables: counter saturates at 15.
    for (int k = 0; k < 17; k++) begin
      send_syll(BAD, GOOD, 1, 1, 0, 14);
      if (m_ca != 4'd15) m_ca = m_ca + 4'd1;
      expect_out($sformatf("sat%0d", k), 1, 0, 1, 8'h00, 8'h00, m_ca, m_cb);
      check_out();
    end

    // 18th error with CLRCNT on the parity bit: clear wins.
    send_syll(BAD, GOOD, 1, 1, 1, 14);
    m_ca = 4'd0;
    expect_out("clr_vs_inc", 1, 0, 1, 8'h00, 8'h00, m_ca, m_cb);
    check_out();
    drive_bit(0, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0);
    idle();

    // Drive-sense latches.
    drive_bit(1, 0, 0, 1, 1, 0, 0, 0, 1, 3'd5);
    expect_out("edy5", 0, 0, 0, 8'h00, 8'h20, m_ca, m_cb);
    check_out();
    drive_bit(1, 0, 0, 1, 1, 1, 0, 1, 0, 3'd2);
    expect_out("sync_set", 0, 0, 0, 8'h04, 8'h00, m_ca, m_cb);
    check_out();
    drive_bit(1, 0, 0, 1, 1, 0, 0, 1, 0, 3'd7);
    expect_out("edx7", 0, 0, 0, 8'h84, 8'h00, m_ca, m_cb);
    check_out();
    drive_bit(1, 0, 0, 1, 0, 0, 0, 1, 0, 3'd0);
    expect_out("ed_time0", 0, 0, 0, 8'h84, 8'h00, m_ca, m_cb);
    check_out();
    idle();

    // Build EDX=FF and ERRCNT_B=3, then reset mid-syllable.
    for (int k = 0; k < 3; k++) begin
      send_syll(GOOD, BAD, 1, 1, 0, 14);
      m_cb = m_cb + 4'd1;
      expect_out($sformatf("b_err%0d", k), 0, 1, 1, 8'h84, 8'h00, m_ca, m_cb);
      check_out();
    end
    for (int m = 0; m < 8; m++) begin
      drive_bit(1, 0, 0, 1, 1, 0, 0, 1, 0, 3'(m));
    end
    idle();
    expect_out("pre_reset", 0, 0, 1, 8'hFF, 8'h00, m_ca, m_cb);
    check_out();

    send_syll(GOOD, GOOD, 1, 1, 0, 6);
    bit_en = 1; tim = 1;
    resetn = 1'b0;
    #1;
    m_ca = 4'd0; m_cb = 4'd0;
    expect_out("async_reset", 0, 0, 0, 8'h00, 8'h00, m_ca, m_cb);
    check_out();
    idle();
    @(negedge clk);
    resetn = 1'b1;

    send_syll(GOOD, GOOD, 1, 1, 0, 14);
    expect_out("post_reset", 0, 0, 0, 8'h00, 8'h00, m_ca, m_cb);
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
